// File: rtl/line_cmd_arbiter_if.sv
// Requester and line-engine signal bundle for line_cmd_arbiter.
// slave: arbiter side; master: requesters plus engine side.
interface line_cmd_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*40-1:0] cmd_line;
  logic [NUM_REQ-1:0]    ack;
  logic                  ack_err;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [15:0]           line_count;
  logic [9:0]            eng_x1;
  logic [9:0]            eng_y1;
  logic [9:0]            eng_x2;
  logic [9:0]            eng_y2;
  logic                  eng_draw;
  logic [2:0]            eng_op;
  logic                  eng_done;

  modport slave (
    input  req,
    input  cmd_line,
    input  eng_done,
    output ack,
    output ack_err,
    output grant,
    output busy,
    output line_count,
    output eng_x1,
    output eng_y1,
    output eng_x2,
    output eng_y2,
    output eng_draw,
    output eng_op
  );

  modport master (
    output req,
    output cmd_line,
    output eng_done,
    input  ack,
    input  ack_err,
    input  grant,
    input  busy,
    input  line_count,
    input  eng_x1,
    input  eng_y1,
    input  eng_x2,
    input  eng_y2,
    input  eng_draw,
    input  eng_op
  );
endinterface

// File: rtl/line_cmd_arbiter.sv
// Round-robin arbiter/sequencer sharing one Bresenham line engine.
// Ports: clk, reset (sync, active-high), bus (line_cmd_arbiter_if.slave):
//   req/cmd_line in, ack/ack_err/grant/busy/line_count out,
//   eng_x1..eng_y2/eng_draw/eng_op out, eng_done in.
module line_cmd_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter int         TIMEOUT = 4096,
  parameter int         TW      = 13,
  parameter logic [2:0] LINE_OP = 3'b100
) (
  input logic               clk,
  input logic               reset,
  line_cmd_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE
  } state_t;

  state_t             state;
  logic [PW-1:0]      rr;
  logic [PW-1:0]      owner;
  logic [TW-1:0]      cnt;
  logic               seen_low;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack;
  logic               ack_err;
  logic               busy;
  logic               draw;
  logic [15:0]        line_count;
  logic [9:0]         x1;
  logic [9:0]         y1;
  logic [9:0]         x2;
  logic [9:0]         y2;

  logic [39:0]        cmds [NUM_REQ];
  logic [SW-1:0]      sum;
  logic               pick_ok;
  logic [PW-1:0]      pick;
  logic [39:0]        pick_cmd;
  logic [NUM_REQ-1:0] pick_oh;
  logic               degen;
  logic               done_now;
  logic [PW-1:0]      rr_next;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign cmds[i] = bus.cmd_line[i*40 +: 40];
  end

  // Walk downward so the lowest offset from rr is the last hit kept.
  always_comb begin
    sum     = '0;
    pick_ok = 1'b0;
    pick    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      if (bus.req[sum[PW-1:0]]) begin
        pick_ok = 1'b1;
        pick    = sum[PW-1:0];
      end
    end
  end

  assign pick_cmd = cmds[pick];
  assign pick_oh  = NUM_REQ'(1) << pick;

  // The engine ignores zero-length lines, so they never get a draw.
  assign degen = (pick_cmd[39:30] == pick_cmd[19:10]) &&
                 (pick_cmd[29:20] == pick_cmd[9:0]);

  // A done still high from the previous line is stale until seen low.
  assign done_now = bus.eng_done && seen_low;

  assign rr_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= '0;
      owner      <= '0;
      cnt        <= '0;
      seen_low   <= 1'b0;
      grant      <= '0;
      ack        <= '0;
      ack_err    <= 1'b0;
      busy       <= 1'b0;
      draw       <= 1'b0;
      line_count <= '0;
      x1         <= '0;
      y1         <= '0;
      x2         <= '0;
      y2         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            owner            <= pick;
            grant            <= pick_oh;
            {x1, y1, x2, y2} <= pick_cmd;
            busy             <= 1'b1;
            if (degen) begin
              state   <= RELEASE;
              ack     <= pick_oh;
              ack_err <= 1'b0;
            end else begin
              state <= ISSUE;
              draw  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          draw     <= 1'b0;
          cnt      <= '0;
          seen_low <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (!bus.eng_done) begin
            seen_low <= 1'b1;
          end
          if (done_now) begin
            state   <= RELEASE;
            ack     <= grant;
            ack_err <= 1'b0;
          end else if (cnt == TLAST) begin
            state   <= RELEASE;
            ack     <= grant;
            ack_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          ack     <= '0;
          ack_err <= 1'b0;
          grant   <= '0;
          busy    <= 1'b0;
          if (!ack_err) begin
            line_count <= line_count + 16'd1;
          end
          rr    <= rr_next;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack;
  assign bus.ack_err    = ack_err;
  assign bus.grant      = grant;
  assign bus.busy       = busy;
  assign bus.line_count = line_count;
  assign bus.eng_x1     = x1;
  assign bus.eng_y1     = y1;
  assign bus.eng_x2     = x2;
  assign bus.eng_y2     = y2;
  assign bus.eng_draw   = draw;

  // Held at LINE_OP during reset so the engine's own reset takes effect.
  assign bus.eng_op = (reset || busy) ? LINE_OP : 3'b000;

endmodule

// File: tb/tb_line_cmd_arbiter.sv
// Randomized scoreboard bench for line_cmd_arbiter.
// Requesters, engine model and checker run as separate processes.
module tb_line_cmd_arbiter;
  localparam int N = 4;
  localparam int TO = 4096;
  localparam logic [2:0] LOP = 3'b100;
  localparam int NORMAL = 0;
  localparam int DEAD = 1;
  localparam int STUCK = 2;

  typedef struct {
    int who;
    logic [39:0] cmd;
  } job_t;

  typedef struct {
    int who;
    bit err;
    bit degen;
    logic [39:0] cmd;
    int lc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  line_cmd_arbiter_if #(.NUM_REQ(N)) bus ();

  line_cmd_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT(TO),
    .TW(13),
    .LINE_OP(LOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = NORMAL;
  int rise_cyc = -1;
  int draws = 0;
  int exp_draws = 0;
  int m_rr = 0;
  int m_lc = 0;
  exp_t sb[$];
  job_t jobs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] rcmd(input bit dg);
    logic [9:0] a, b, c, d;
    a = 10'($urandom_range(0, 1023));
    b = 10'($urandom_range(0, 1023));
    c = 10'($urandom_range(0, 1023));
    d = 10'($urandom_range(0, 1023));
    if (dg) return {a, b, a, b};
    if (a == c && b == d) c = a ^ 10'd1;
    return {a, b, c, d};
  endfunction

  // Engine: after a draw, keep done as-is a few cycles, drop, then raise.
  int eph = 0;
  int edly = 0;
  int elow = 0;
  initial begin
    bus.eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eng_draw) begin
        if (mode == NORMAL) begin
          edly = $urandom_range(1, 4);
          elow = $urandom_range(1, 4);
          eph = 1;
        end else begin
          eph = 0;
          if (mode == DEAD) bus.eng_done = 1'b0;
        end
      end else if (eph == 1) begin
        edly--;
        if (edly == 0) begin
          bus.eng_done = 1'b0;
          eph = 2;
        end
      end else if (eph == 2) begin
        elow--;
        if (elow == 0) begin
          bus.eng_done = 1'b1;
          rise_cyc = cyc;
          eph = 0;
        end
      end
    end
  end

  // Checker: pops one expectation per ack.
  logic [N-1:0] prev_grant = '0;
  logic prev_draw = 1'b0;
  int gstart = 0;
  exp_t me;
  int lat;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_grant = '0;
        prev_draw = 1'b0;
      end else begin
        if (bus.grant != '0 && prev_grant == '0) gstart = cyc;
        if (bus.eng_draw) begin
          draws++;
          chk("draw_single", 64'(prev_draw), 64'd0);
          chk("draw_cycle", 64'(cyc - gstart), 64'd0);
        end
        if (bus.ack != '0) begin
          if (sb.size() == 0) begin
            chk("unexpected_ack", 64'(bus.ack), 64'd0);
          end else begin
            me = sb.pop_front();
            chk("ack_who", 64'(bus.ack), 64'(N'(1) << me.who));
            chk("ack_grant", 64'(bus.grant), 64'(N'(1) << me.who));
            chk("ack_err", 64'(bus.ack_err), 64'(me.err));
            chk("ack_coords",
                64'({bus.eng_x1, bus.eng_y1, bus.eng_x2, bus.eng_y2}),
                64'(me.cmd));
            chk("ack_line_count", 64'(bus.line_count), 64'(16'(me.lc)));
            chk("ack_busy", 64'(bus.busy), 64'd1);
            if (me.degen) lat = gstart;
            else if (me.err) lat = gstart + TO + 1;
            else lat = rise_cyc + 1;
            chk("ack_latency", 64'(cyc), 64'(lat));
          end
        end
        prev_grant = bus.grant;
        prev_draw = bus.eng_draw;
      end
    end
  end

  // Issues the queued jobs, predicts the rr grant order, and plays the
  // requesters: drop req after ack, re-raise two cycles later if more.
  task automatic run_batch(input int md);
    job_t pend[$];
    job_t mq[$];
    exp_t e;
    int rcnt[N];
    int w, c, got, ntot, budget;
    bit more;
    mode = md;
    pend = jobs;
    jobs.delete();
    ntot = pend.size();
    mq = pend;
    while (mq.size() > 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (w < 0) foreach (mq[j]) if (mq[j].who == c) w = c;
      end
      for (int j = 0; j < mq.size(); j++) begin
        if (mq[j].who == w) begin
          e.who = w;
          e.cmd = mq[j].cmd;
          e.degen = (e.cmd[39:20] == e.cmd[19:0]);
          e.err = !e.degen && (md != NORMAL);
          e.lc = m_lc;
          if (!e.err) m_lc++;
          if (!e.degen) exp_draws++;
          sb.push_back(e);
          mq.delete(j);
          break;
        end
      end
      m_rr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      rcnt[i] = 0;
      for (int j = 0; j < pend.size(); j++) begin
        if (pend[j].who == i) begin
          bus.cmd_line[i*40 +: 40] = pend[j].cmd;
          bus.req[i] = 1'b1;
          pend.delete(j);
          break;
        end
      end
    end
    got = 0;
    budget = ntot * (TO + 64) + 64;
    while (got < ntot && budget > 0) begin
      @(negedge clk);
      budget--;
      for (int i = 0; i < N; i++) begin
        if (rcnt[i] > 0) begin
          rcnt[i]--;
          if (rcnt[i] == 0) begin
            for (int j = 0; j < pend.size(); j++) begin
              if (pend[j].who == i) begin
                bus.cmd_line[i*40 +: 40] = pend[j].cmd;
                bus.req[i] = 1'b1;
                pend.delete(j);
                break;
              end
            end
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          bus.req[i] = 1'b0;
          got++;
          more = 1'b0;
          foreach (pend[j]) if (pend[j].who == i) more = 1'b1;
          if (more) rcnt[i] = 2;
        end else if (bus.grant[i]) begin
          bus.cmd_line[i*40 +: 40] = {8'($urandom), 32'($urandom)};
        end
      end
    end
    if (got < ntot) begin
      chk("batch_done", 64'(got), 64'(ntot));
      bus.req = '0;
    end
    @(negedge clk);
    chk("post_line_count", 64'(bus.line_count), 64'(16'(m_lc)));
    chk("post_busy", 64'(bus.busy), 64'd0);
    chk("post_grant", 64'(bus.grant), 64'd0);
  endtask

  int nj;
  logic [N-1:0] mask;
  logic [39:0] ca, cb;

  initial begin
    bus.req = '0;
    bus.cmd_line = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_eng_op", 64'(bus.eng_op), 64'(LOP));
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_ack", 64'({bus.ack, bus.ack_err}), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_draw", 64'(bus.eng_draw), 64'd0);
    chk("rst_line_count", 64'(bus.line_count), 64'd0);
    chk("rst_coords",
        64'({bus.eng_x1, bus.eng_y1, bus.eng_x2, bus.eng_y2}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_eng_op", 64'(bus.eng_op), 64'd0);

    jobs.push_back('{0, {10'd0, 10'd0, 10'd5, 10'd3}});
    run_batch(NORMAL);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) jobs.push_back('{i, rcmd(1'b0)});
    run_batch(NORMAL);

    jobs.push_back('{2, {10'd7, 10'd7, 10'd7, 10'd7}});
    run_batch(NORMAL);

    jobs.push_back('{1, rcmd(1'b0)});
    run_batch(STUCK);
    jobs.push_back('{1, rcmd(1'b0)});
    run_batch(NORMAL);

    jobs.push_back('{0, rcmd(1'b0)});
    jobs.push_back('{3, rcmd(1'b0)});
    jobs.push_back('{2, rcmd(1'b1)});
    run_batch(DEAD);

    for (int b = 0; b < 15; b++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          nj = $urandom_range(1, 3);
          for (int j = 0; j < nj; j++)
            jobs.push_back('{i, rcmd($urandom_range(0, 3) == 0)});
        end
      end
      run_batch(NORMAL);
    end

    ca = rcmd(1'b0);
    cb = rcmd(1'b0);
    mode = DEAD;
    bus.cmd_line[1*40 +: 40] = ca;
    bus.cmd_line[2*40 +: 40] = cb;
    bus.req = 4'b0110;
    exp_draws++;
    repeat (20) @(negedge clk);
    chk("mid_wait_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_eng_op", 64'(bus.eng_op), 64'(LOP));
    chk("mid_rst_grant", 64'(bus.grant), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ack", 64'(bus.ack), 64'd0);
    chk("mid_rst_line_count", 64'(bus.line_count), 64'd0);
    reset = 1'b0;
    m_rr = 0;
    m_lc = 0;
    sb.delete();
    jobs.push_back('{1, ca});
    jobs.push_back('{2, cb});
    run_batch(NORMAL);

    repeat (4) @(negedge clk);
    chk("draw_total", 64'(draws), 64'(exp_draws));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
